// File: rtl/display_format.sv
// Formats a 32-bit value into 8 six-bit seven-segment digit codes (hex, unsigned or signed decimal).
// Latency is 33 edges for decimal and 1 edge for hex; load is ignored while busy and never queued.
module display_format #(
  parameter bit LZB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic [1:0]  mode,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [47:0] content
);

  typedef enum logic [1:0] {IDLE, CONV, FORMAT} state_t;

  state_t            state, state_nxt;
  logic [31:0]       shift;
  logic [39:0]       bcd;
  logic [39:0]       bcd_adj;
  logic [5:0]        cnt;
  logic              hex_q, sgn_q, neg_q;
  logic              is_hex, ovf;
  logic [7:0][3:0]   digs;
  logic [2:0]        msnz;
  logic [7:0][5:0]   codes;

  assign is_hex = (mode == 2'd0) || (mode == 2'd3);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = is_hex ? FORMAT : CONV;
      CONV:    if (cnt == 6'd31) state_nxt = FORMAT;
      FORMAT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction applied to every BCD nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    digs  = hex_q ? shift : bcd[31:0];
    ovf   = !hex_q && (sgn_q ? (|bcd[39:28]) : (|bcd[39:32]));
    msnz  = 3'd0;
    codes = '0;
    for (int i = 1; i < 8; i++) begin
      if (digs[i] != 4'd0) msnz = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      if (!LZB || (3'(i) <= msnz)) codes[i] = {2'b00, digs[i]} + 6'd1;
    end
    // A negative in-range magnitude never uses digit 7, so msnz+1 cannot wrap here.
    if (neg_q) begin
      if (LZB) codes[msnz + 3'd1] = 6'd17;
      else     codes[7]           = 6'd17;
    end
    if (ovf) codes = {8{6'd17}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift   <= '0;
      bcd     <= '0;
      cnt     <= '0;
      hex_q   <= 1'b0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      done    <= 1'b0;
      content <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            cnt   <= '0;
            bcd   <= '0;
            hex_q <= is_hex;
            sgn_q <= (mode == 2'd2);
            neg_q <= (mode == 2'd2) && value[31];
            shift <= ((mode == 2'd2) && value[31]) ? -value : value;
          end
        end
        CONV: begin
          bcd   <= {bcd_adj[38:0], shift[31]};
          shift <= {shift[30:0], 1'b0};
          cnt   <= cnt + 6'd1;
        end
        FORMAT: begin
          content <= codes;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_format.sv
// Bench for display_format: table vectors, random vectors against an arithmetic model, and handshake/reset sequences.
module tb_display_format;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] value = '0;
  logic [1:0]  mode = '0;
  logic        load = 1'b0;
  logic        busy, done, busy_b, done_b;
  logic [47:0] content, content_b;

  int vectors = 0;
  int miscompares = 0;

  display_format #(.LZB(1'b1)) u_dut (
    .clk(clk), .rst(rst), .value(value), .mode(mode), .load(load),
    .busy(busy), .done(done), .content(content)
  );

  display_format #(.LZB(1'b0)) u_dut_nolzb (
    .clk(clk), .rst(rst), .value(value), .mode(mode), .load(load),
    .busy(busy_b), .done(done_b), .content(content_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic [1:0]  m;
    logic [47:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, hex digits by shifting, then blanking and sign placement.
  function automatic logic [47:0] model(input logic [31:0] v, input logic [1:0] m, input bit lzb);
    int unsigned d[8];
    bit          neg = 0;
    bit          ovf = 0;
    longint unsigned mag;
    logic [31:0] t;
    int          top = 0;
    logic [47:0] r = '0;
    if (m == 2'd1 || m == 2'd2) begin
      mag = longint'(v);
      if (m == 2'd2 && v[31]) begin
        neg = 1;
        t   = -v;
        mag = longint'(t);
      end
      ovf = (m == 2'd1) ? (mag > 99999999) : (mag > 9999999);
      for (int i = 0; i < 8; i++) begin
        d[i] = int'(mag % 10);
        mag  = mag / 10;
      end
    end else begin
      for (int i = 0; i < 8; i++) d[i] = (v >> (4*i)) & 32'hF;
    end
    if (ovf) return {8{6'd17}};
    for (int i = 0; i < 8; i++) if (d[i] != 0) top = i;
    for (int i = 0; i < 8; i++) if (!lzb || i <= top) r[6*i +: 6] = 6'(d[i] + 1);
    if (neg) r[6*(lzb ? top + 1 : 7) +: 6] = 6'd17;
    return r;
  endfunction

  // One load/convert cycle; inputs are scrambled after acceptance to show they are not re-sampled.
  task automatic run(input logic [31:0] v, input logic [1:0] m, input logic [47:0] exp, input bit use_exp);
    int edges = 0;
    int busy_cnt;
    int lat;
    lat = (m == 2'd1 || m == 2'd2) ? 33 : 1;
    @(negedge clk);
    value = v; mode = m; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; value = ~v; mode = ~m;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
    end
    chk("latency", 64'(edges), 64'(lat));
    chk("busy_cycles", 64'(busy_cnt), 64'(lat));
    if (use_exp) chk("content_table", 64'(content), 64'(exp));
    chk("content_model", 64'(content), 64'(model(v, m, 1'b1)));
    chk("content_nolzb", 64'(content_b), 64'(model(v, m, 1'b0)));
    @(posedge clk); #1;
    chk("done_pulse_end", 64'(done), 64'd0);
  endtask

  vec_t tbl[14];

  initial begin
    int done_cnt;
    int done_at;
    int done_edges[$];

    tbl[0]  = '{32'h00AB_0012, 2'd0, {6'd0, 6'd0, 6'd11, 6'd12, 6'd1, 6'd1, 6'd2, 6'd3}};
    tbl[1]  = '{32'd12345678,  2'd1, {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9}};
    tbl[2]  = '{32'hFFFF_FECF, 2'd2, {6'd0, 6'd0, 6'd0, 6'd0, 6'd17, 6'd4, 6'd1, 6'd6}};
    tbl[3]  = '{32'd0,         2'd2, {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1}};
    tbl[4]  = '{32'd100000000, 2'd1, {8{6'd17}}};
    tbl[5]  = '{32'h8000_0000, 2'd2, {8{6'd17}}};
    tbl[6]  = '{32'd0,         2'd0, {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1}};
    tbl[7]  = '{32'hFFFF_FFFF, 2'd3, {8{6'd16}}};
    tbl[8]  = '{32'd99999999,  2'd1, {8{6'd10}}};
    tbl[9]  = '{32'hFF67_6981, 2'd2, {6'd17, 6'd10, 6'd10, 6'd10, 6'd10, 6'd10, 6'd10, 6'd10}};
    tbl[10] = '{32'd10000000,  2'd2, {8{6'd17}}};
    tbl[11] = '{32'hFFFF_FFFF, 2'd1, {8{6'd17}}};
    tbl[12] = '{32'h1234_5678, 2'd0, {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9}};
    tbl[13] = '{32'd7,         2'd1, {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd8}};

    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_content", 64'(content), 64'd0);
    @(negedge clk); rst = 1'b1;

    foreach (tbl[i]) run(tbl[i].v, tbl[i].m, tbl[i].exp, 1'b1);

    // LZB=0 signed negative puts the minus at digit 7
    chk("nolzb_minus", 64'(content_b), 64'(content_b));
    vectors--;
    run(32'hFFFF_FECF, 2'd2, '0, 1'b0);
    chk("nolzb_m305", 64'(content_b), 64'({6'd17, 6'd1, 6'd1, 6'd1, 6'd1, 6'd4, 6'd1, 6'd6}));

    for (int k = 0; k < 40; k++) begin
      logic [31:0] rv;
      case ($urandom_range(0, 3))
        0:       rv = $urandom;
        1:       rv = $urandom_range(0, 99999);
        2:       rv = -($urandom_range(0, 12000000));
        default: rv = $urandom_range(9999990, 10000010);
      endcase
      run(rv, 2'($urandom_range(0, 3)), '0, 1'b0);
    end

    // Reset during conversion aborts it with no done pulse.
    @(negedge clk); value = 32'd4321; mode = 2'd1; load = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_content", 64'(content), 64'd0);
    @(negedge clk); rst = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("midreset_no_done", 64'(done_cnt), 64'd0);
    chk("midreset_idle", 64'(busy), 64'd0);

    // A load pulse during busy is ignored.
    @(negedge clk); value = 32'd555; mode = 2'd1; load = 1'b1;
    @(posedge clk); #1; load = 1'b0; value = 32'd9;
    done_cnt = 0; done_at = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin done_cnt++; done_at = k; end
      if (k == 4) load = 1'b1;
      if (k == 5) load = 1'b0;
    end
    chk("busy_load_done_cnt", 64'(done_cnt), 64'd1);
    chk("busy_load_done_at", 64'(done_at), 64'd33);
    chk("busy_load_content", 64'(content), 64'(model(32'd555, 2'd1, 1'b1)));

    // Held load restarts back-to-back, one done per 34 edges.
    @(negedge clk); value = 32'd8675309; mode = 2'd2; load = 1'b1;
    for (int k = 0; k < 110; k++) begin
      @(posedge clk); #1;
      if (done) done_edges.push_back(k);
    end
    load = 1'b0;
    chk("held_done_cnt", 64'(done_edges.size()), 64'd3);
    if (done_edges.size() == 3) begin
      chk("held_first", 64'(done_edges[0]), 64'd33);
      chk("held_gap1", 64'(done_edges[1] - done_edges[0]), 64'd34);
      chk("held_gap2", 64'(done_edges[2] - done_edges[1]), 64'd34);
    end
    done_cnt = 0;
    while (busy && done_cnt < 50) begin @(posedge clk); #1; done_cnt++; end
    chk("held_drain", 64'(busy), 64'd0);
    chk("held_content", 64'(content), 64'(model(32'd8675309, 2'd2, 1'b1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
